twos_complement_serial: RTL and testbench
=========================================

// Module: twos_complement_serial
// PURPOSE
//  Chunk-serial, parametrised two's-complement unit: pass, negate or absolute value of a
//  WIDTH-bit operand, CHUNK bits per clock, ripple carry held in a register between chunks.
//  Serves the FP add/sub datapath (mantissa/exponent-difference negation) where area beats
//  latency. Valid/ready on input and output; flags the most-negative-value overflow.
// PARAMETERS
//  WIDTH  11  operand/result width in bits, >= 2
//  CHUNK  1   bits processed per cycle; WIDTH % CHUNK == 0 (elaboration error otherwise)
//  (derived) NCHUNK = WIDTH/CHUNK; CW = clog2(NCHUNK) (min 1), chunk counter width
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand present
//  in_ready   out  1      unit can accept; transfer when in_valid & in_ready
//  in_data    in   WIDTH  operand, two's complement
//  in_mode    in   2      00 pass, 01 negate, 10 abs, 11 reserved (treated as pass)
//  out_valid  out  1      result present
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  out_data   out  WIDTH  result
//  out_ovf    out  1      result not representable (negate/abs of 1000..0)
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, out_valid=0, out_data=0, out_ovf=0, carry=0, counter=0; in_ready=1
//   and busy=0 (state-decoded). Reset mid-RUN/DONE aborts; operand discarded, no out_valid.
//  FSM IDLE -> RUN -> DONE -> (IDLE | RUN).
//   IDLE: in_ready=1. On accept: latch in_data into operand shift reg; inv = (mode==01) |
//    (mode==10 & in_data[WIDTH-1]); carry=inv; ovf_r = inv & (in_data == {1'b1,{WIDTH-1{0}}});
//    counter=NCHUNK-1; -> RUN.
//   RUN: each cycle take low CHUNK bits c of operand; {carry,s} = (inv ? ~c : c) + carry;
//    shift operand right by CHUNK; shift s into result reg from the top. Counter==0 -> DONE
//    with out_valid=1, out_data=result, out_ovf=ovf_r, all on the same edge.
//   DONE: out_valid=1; out_data/out_ovf stable while out_ready=0.
//    in_ready = out_ready (back-to-back): both handshakes -> accept new operand, -> RUN,
//    out_valid=0. out_ready only -> IDLE, out_valid=0.
//  Latency: accept on edge e -> out_valid high after edge e+NCHUNK. Sustained throughput one
//   operand per NCHUNK cycles with out_ready held high.
//  in_data/in_mode sampled only on accept; later changes ignored. in_valid in RUN ignored.
//  Final carry discarded (mod 2^WIDTH). Negate 0 -> 0, ovf=0. Negate/abs of 100..0 ->
//   100..0, ovf=1. Pass/reserved never set ovf; still take NCHUNK cycles.
//  CHUNK==WIDTH: single RUN cycle, latency 1.
// STRUCTURE
//  Include file twos_comp_defs.vh: mode encodings (MODE_PASS/NEG/ABS/RSVD), FSM state
//   encodings (ST_IDLE/RUN/DONE), 2-bit widths for both.
//  Sub-module chunk_cinc: combinational CHUNK-bit conditional-invert-plus-carry
//   (inputs c, inv, cin; outputs s, cout); instantiated once, the only arithmetic.
//  Top: FSM, counter, operand/result shift regs, carry/inv/ovf flops, output regs.
// TESTING (WIDTH=11, CHUNK=1 unless noted)
//  1. mode=01, 11'h001 -> out_data 11'h7FF, ovf 0, out_valid exactly 11 cycles after accept;
//     11'h000 -> 11'h000, ovf 0.
//  2. mode=10: 11'h7FF -> 11'h001; 11'h3FF -> 11'h3FF; mode=00/11: 11'h555 -> 11'h555.
//  3. mode=01 and mode=10 on 11'h400 -> out_data 11'h400, out_ovf 1.
//  4. out_ready low 5 cycles in DONE: out_data/out_ovf stable, in_ready 0; then out_ready and
//     in_valid high same cycle -> back-to-back ops, result every 11 cycles.
//  5. rst_n low at 4th RUN cycle: out_valid 0, busy 0 immediately; next op (negate 11'h00A)
//     -> 11'h7F6.
//  6. WIDTH=16,CHUNK=4 and WIDTH=11,CHUNK=11: 1000 random operands/modes vs model
//     (mode? -x : x mod 2^WIDTH), latency NCHUNK, ovf matches.

Source files
------------

// File: rtl/twos_complement_serial_pkg.sv
// Shared encodings for the chunk-serial two's-complement unit: FSM states,
// operation modes and the mode decode that decides whether an operand is inverted.
package twos_complement_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_NEG  = 2'd1,
    MODE_ABS  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  // Negation is ~x + 1, so "invert" also seeds the carry-in; reserved behaves as pass.
  function automatic logic needs_invert(input logic [1:0] mode, input logic sign);
    return (mode == MODE_NEG) || ((mode == MODE_ABS) && sign);
  endfunction

endpackage

// File: rtl/twos_complement_serial_chunk_cinc.sv
// CHUNK-bit conditional invert plus carry-in: {cout, s} = (inv ? ~c : c) + cin.
// This is the only adder in the serial unit; the carry ripples between chunks via a flop.
module chunk_cinc #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] c,
  input  logic             inv,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] sum;

  assign sum  = {1'b0, c ^ {CHUNK{inv}}} + {{CHUNK{1'b0}}, cin};
  assign s    = sum[CHUNK-1:0];
  assign cout = sum[CHUNK];

endmodule

// File: rtl/twos_complement_serial.sv
// Chunk-serial pass / negate / abs of a WIDTH-bit two's-complement operand,
// CHUNK bits per clock, with overflow flag for negating the most-negative value.
module twos_complement_serial
  import twos_complement_serial_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  if ((WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("twos_complement_serial: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             inv;
  logic             ovf_r;

  logic             accept;
  logic             inv_in;
  logic [CHUNK-1:0] sum_chunk;
  logic             sum_cout;
  logic [WIDTH-1:0] result_nxt;
  logic [WIDTH-1:0] operand_shr;

  // Valid/ready: a transfer happens on a rising edge where valid & ready are both high.
  // Producers hold data stable while valid is high and ready is low; ready may depend
  // combinationally on the partner's ready (in_ready follows out_ready in DONE).
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;
  assign inv_in    = needs_invert(in_mode, in_data[WIDTH-1]);

  chunk_cinc #(.CHUNK(CHUNK)) u_cinc (
    .c    (operand[CHUNK-1:0]),
    .inv  (inv),
    .cin  (carry),
    .s    (sum_chunk),
    .cout (sum_cout)
  );

  // Result fills from the top so the first (least significant) chunk ends at bit 0.
  if (NCHUNK == 1) begin : g_single
    assign result_nxt  = sum_chunk;
    assign operand_shr = '0;
  end else begin : g_multi
    assign result_nxt  = {sum_chunk, result[WIDTH-1:CHUNK]};
    assign operand_shr = {{CHUNK{1'b0}}, operand[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      operand   <= '0;
      result    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      inv       <= 1'b0;
      ovf_r     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      // Accept is only possible from IDLE or DONE; a DONE accept is also the output handshake.
      operand   <= in_data;
      inv       <= inv_in;
      carry     <= inv_in;
      ovf_r     <= inv_in && (in_data == MOST_NEG);
      cnt       <= CNT_LAST;
      out_valid <= 1'b0;
      state     <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          operand <= operand_shr;
          result  <= result_nxt;
          carry   <= sum_cout;
          cnt     <= cnt - CW'(1);
          if (cnt == '0) begin
            out_valid <= 1'b1;
            out_data  <= result_nxt;
            out_ovf   <= ovf_r;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_IDLE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twos_complement_serial.sv
// Bench for twos_complement_serial: directed table, stall/back-to-back and reset-abort
// sequences on WIDTH=11/CHUNK=1, plus random operands on 11/1, 16/4 and 11/11.
module tb_twos_complement_serial;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // unit 0: WIDTH=11 CHUNK=1
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_ovf_a, busy_a;
  logic [10:0] in_data_a, out_data_a;
  logic [1:0]  in_mode_a, dbg_a;
  // unit 1: WIDTH=16 CHUNK=4
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_ovf_b, busy_b;
  logic [15:0] in_data_b, out_data_b;
  logic [1:0]  in_mode_b, dbg_b;
  // unit 2: WIDTH=11 CHUNK=11
  logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_ovf_c, busy_c;
  logic [10:0] in_data_c, out_data_c;
  logic [1:0]  in_mode_c, dbg_c;

  twos_complement_serial #(.WIDTH(11), .CHUNK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .in_mode(in_mode_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .out_ovf(out_ovf_a),
    .busy(busy_a), .dbg_state(dbg_a)
  );
  twos_complement_serial #(.WIDTH(16), .CHUNK(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_mode(in_mode_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .out_ovf(out_ovf_b),
    .busy(busy_b), .dbg_state(dbg_b)
  );
  twos_complement_serial #(.WIDTH(11), .CHUNK(11)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .in_data(in_data_c), .in_mode(in_mode_c), .out_valid(out_valid_c),
    .out_ready(out_ready_c), .out_data(out_data_c), .out_ovf(out_ovf_c),
    .busy(busy_c), .dbg_state(dbg_c)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];  // {ovf, data}

  typedef struct {
    logic [10:0] data;
    logic [1:0]  mode;
    logic [10:0] exp_data;
    logic        exp_ovf;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-unit access ----------------
  function automatic int unit_width(input int u);
    return (u == 1) ? 16 : 11;
  endfunction

  function automatic int unit_nchunk(input int u);
    case (u)
      0: return 11;
      1: return 4;
      default: return 1;
    endcase
  endfunction

  task automatic set_in(input int u, input logic v, input logic [15:0] d, input logic [1:0] m);
    case (u)
      0: begin in_valid_a = v; in_data_a = d[10:0]; in_mode_a = m; end
      1: begin in_valid_b = v; in_data_b = d;       in_mode_b = m; end
      default: begin in_valid_c = v; in_data_c = d[10:0]; in_mode_c = m; end
    endcase
  endtask

  task automatic set_out_ready(input int u, input logic r);
    case (u)
      0: out_ready_a = r;
      1: out_ready_b = r;
      default: out_ready_c = r;
    endcase
  endtask

  function automatic logic get_ov(input int u);
    case (u) 0: return out_valid_a; 1: return out_valid_b; default: return out_valid_c; endcase
  endfunction
  function automatic logic [15:0] get_od(input int u);
    case (u) 0: return {5'd0, out_data_a}; 1: return out_data_b; default: return {5'd0, out_data_c}; endcase
  endfunction
  function automatic logic get_ovf(input int u);
    case (u) 0: return out_ovf_a; 1: return out_ovf_b; default: return out_ovf_c; endcase
  endfunction
  function automatic logic get_ir(input int u);
    case (u) 0: return in_ready_a; 1: return in_ready_b; default: return in_ready_c; endcase
  endfunction
  function automatic logic get_busy(input int u);
    case (u) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction

  // Reference: interpret x as a signed WIDTH-bit number and compute the wanted value,
  // then reduce modulo 2^WIDTH. Overflow when the true answer is 2^(WIDTH-1).
  task automatic model(input int u, input logic [15:0] x, input logic [1:0] m,
                       output logic [15:0] r, output logic ovf);
    longint w    = unit_width(u);
    longint modv = longint'(1) << w;
    longint xv   = longint'(x) % modv;
    longint sv   = (xv >= modv / 2) ? xv - modv : xv;
    longint want;
    case (m)
      2'b01:   want = -sv;
      2'b10:   want = (sv < 0) ? -sv : sv;
      default: want = sv;
    endcase
    ovf  = (want == modv / 2);
    r    = 16'(((want % modv) + modv) % modv);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_valid(input int u, output int lat);
    lat = 0;
    while (!get_ov(u) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_timeout", 16'(get_ov(u)), 16'd1);
  endtask

  // One complete transaction from IDLE; returns result, flag and accept-to-valid latency.
  task automatic do_op(input int u, input logic [15:0] x, input logic [1:0] m,
                       output logic [15:0] r, output logic ovf, output int lat);
    @(negedge clk);
    set_in(u, 1'b1, x, m);
    #1;
    check("in_ready_idle", 16'(get_ir(u)), 16'd1);
    @(posedge clk); #1;
    set_in(u, 1'b0, 16'h0000, 2'b00);
    wait_valid(u, lat);
    r   = get_od(u);
    ovf = get_ovf(u);
    set_out_ready(u, 1'b1);
    @(posedge clk); #1;
    set_out_ready(u, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] r, er, x;
    logic        o, eo;
    logic [1:0]  m;
    logic [16:0] e;
    int          lat;
    bit          saw_valid;

    vecs[0]  = '{11'h001, 2'b01, 11'h7FF, 1'b0};
    vecs[1]  = '{11'h000, 2'b01, 11'h000, 1'b0};
    vecs[2]  = '{11'h7FF, 2'b10, 11'h001, 1'b0};
    vecs[3]  = '{11'h3FF, 2'b10, 11'h3FF, 1'b0};
    vecs[4]  = '{11'h555, 2'b00, 11'h555, 1'b0};
    vecs[5]  = '{11'h555, 2'b11, 11'h555, 1'b0};
    vecs[6]  = '{11'h400, 2'b01, 11'h400, 1'b1};
    vecs[7]  = '{11'h400, 2'b10, 11'h400, 1'b1};
    vecs[8]  = '{11'h400, 2'b00, 11'h400, 1'b0};
    vecs[9]  = '{11'h400, 2'b11, 11'h400, 1'b0};
    vecs[10] = '{11'h7FF, 2'b01, 11'h001, 1'b0};
    vecs[11] = '{11'h2A5, 2'b01, 11'h55B, 1'b0};

    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      set_in(u, 1'b0, 16'h0000, 2'b00);
      set_out_ready(u, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      check("rst_out_valid", 16'(get_ov(u)), 16'd0);
      check("rst_out_data", get_od(u), 16'd0);
      check("rst_out_ovf", 16'(get_ovf(u)), 16'd0);
      check("rst_in_ready", 16'(get_ir(u)), 16'd1);
      check("rst_busy", 16'(get_busy(u)), 16'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table on the bit-serial unit.
    for (int i = 0; i < 12; i++) begin
      do_op(0, {5'd0, vecs[i].data}, vecs[i].mode, r, o, lat);
      check($sformatf("vec%0d_data", i), r, {5'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_ovf", i), 16'(o), 16'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_latency", i), 16'(lat), 16'd11);
    end

    // Output stall for 5 cycles, then simultaneous handshakes and back-to-back operands.
    @(negedge clk);
    set_in(0, 1'b1, 16'h0001, 2'b01);
    exp_q.push_back({1'b0, 16'h07FF});
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'h0000, 2'b00);
    wait_valid(0, lat);
    check("stall_latency", 16'(lat), 16'd11);
    e = exp_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      check("stall_out_valid", 16'(get_ov(0)), 16'd1);
      check("stall_out_data", get_od(0), e[15:0]);
      check("stall_out_ovf", 16'(get_ovf(0)), 16'(e[16]));
      check("stall_in_ready", 16'(get_ir(0)), 16'd0);
      @(posedge clk); #1;
    end
    set_out_ready(0, 1'b1);
    set_in(0, 1'b1, 16'h07FF, 2'b10);
    exp_q.push_back({1'b0, 16'h0001});
    #1;
    check("b2b_in_ready", 16'(get_ir(0)), 16'd1);
    @(posedge clk); #1;
    check("b2b_out_valid_drop", 16'(get_ov(0)), 16'd0);
    check("b2b_busy", 16'(get_busy(0)), 16'd1);
    // Held in_valid during RUN must be ignored until the next DONE.
    set_in(0, 1'b1, 16'h0555, 2'b00);
    exp_q.push_back({1'b0, 16'h0555});
    wait_valid(0, lat);
    e = exp_q.pop_front();
    check("b2b1_latency", 16'(lat), 16'd11);
    check("b2b1_data", get_od(0), e[15:0]);
    check("b2b1_ovf", 16'(get_ovf(0)), 16'(e[16]));
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'h0000, 2'b00);
    wait_valid(0, lat);
    e = exp_q.pop_front();
    check("b2b2_latency", 16'(lat), 16'd11);
    check("b2b2_data", get_od(0), e[15:0]);
    check("b2b2_ovf", 16'(get_ovf(0)), 16'(e[16]));
    @(posedge clk); #1;
    set_out_ready(0, 1'b0);
    check("b2b_idle_busy", 16'(get_busy(0)), 16'd0);

    // Reset during the 4th RUN cycle aborts the operation.
    @(negedge clk);
    set_in(0, 1'b1, 16'h0155, 2'b01);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'h0000, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    check("pre_abort_busy", 16'(get_busy(0)), 16'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 16'(get_ov(0)), 16'd0);
    check("abort_busy", 16'(get_busy(0)), 16'd0);
    check("abort_in_ready", 16'(get_ir(0)), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
      if (get_ov(0)) saw_valid = 1'b1;
    end
    check("abort_no_result", 16'(saw_valid), 16'd0);
    do_op(0, 16'h000A, 2'b01, r, o, lat);
    check("post_abort_data", r, 16'h07F6);
    check("post_abort_ovf", 16'(o), 16'd0);
    check("post_abort_latency", 16'(lat), 16'd11);

    // Random operands and modes against the reference model on all three units.
    for (int u = 0; u < 3; u++) begin
      int n_ops = (u == 0) ? 200 : 1000;
      for (int i = 0; i < n_ops; i++) begin
        x = 16'($urandom);
        if ($urandom_range(0, 15) == 0) x = (u == 1) ? 16'h8000 : 16'h0400;
        m = 2'($urandom_range(0, 3));
        model(u, x, m, er, eo);
        do_op(u, x, m, r, o, lat);
        check($sformatf("rand_u%0d_data", u), r, er);
        check($sformatf("rand_u%0d_ovf", u), 16'(o), 16'(eo));
        check($sformatf("rand_u%0d_latency", u), 16'(lat), 16'(unit_nchunk(u)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
